// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 8-bit combinational ALU: accepts instructions, drives
// operands from a 4x8 register file, waits ALU_WAIT cycles, then writes back.
module alu_issue_ctrl #(
    parameter int unsigned ALU_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_result,
    input  logic        alu_cb,
    input  logic [7:0]  alu_ext,
    output logic        done,
    output logic        cb_flag,
    output logic [7:0]  ext_reg,
    input  logic        host_wr_en,
    input  logic [1:0]  host_wr_addr,
    input  logic [7:0]  host_wr_data,
    input  logic [1:0]  host_rd_addr,
    output logic [7:0]  host_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WB
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  regs [4];
    logic [3:0]  counter;
    logic [1:0]  rd_pend;
    logic [7:0]  res_hold;
    logic [7:0]  ext_hold;
    logic        cb_hold;
    logic        wr_reg;
    logic        wr_cb;
    logic        wr_ext;
    logic        instr_unused;

    assign instr_unused = ^instr[1:0];
    assign instr_ready  = (state == IDLE);
    assign done         = (state == WB);
    assign host_rd_data = regs[host_rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instr_valid) state_next = ISSUE;
            ISSUE:   if (counter == '0) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Writeback class of the held opcode: which architectural state it updates.
    always_comb begin
        wr_reg = 1'b0;
        wr_cb  = 1'b0;
        wr_ext = 1'b0;
        casez (alu_op)
            8'b0001????, 8'b0010????, 8'b0000011?: begin
                wr_reg = 1'b1;
                wr_cb  = 1'b1;
            end
            8'b0011????: begin
                wr_reg = 1'b1;
                wr_ext = 1'b1;
            end
            8'b0111????: wr_cb = 1'b1;
            8'b00000001, 8'b00000010, 8'b00000011, 8'b00000100, 8'b00000101,
            8'b0101????, 8'b0110????: wr_reg = 1'b1;
            default: ;
        endcase
    end

    // The WB register write follows the host write so it wins on an address clash.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            counter  <= '0;
            rd_pend  <= '0;
            res_hold <= '0;
            ext_hold <= '0;
            cb_hold  <= 1'b0;
            cb_flag  <= 1'b0;
            ext_reg  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (host_wr_en) begin
                regs[host_wr_addr] <= host_wr_data;
            end
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        alu_op  <= instr[15:8];
                        rd_pend <= instr[7:6];
                        alu_a   <= regs[instr[5:4]];
                        alu_b   <= regs[instr[3:2]];
                        counter <= 4'(ALU_WAIT - 1);
                    end
                end
                ISSUE: begin
                    if (counter == '0) begin
                        res_hold <= alu_result;
                        cb_hold  <= alu_cb;
                        ext_hold <= alu_ext;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                WB: begin
                    if (wr_reg) regs[rd_pend] <= res_hold;
                    if (wr_cb)  cb_flag <= cb_hold;
                    if (wr_ext) ext_reg <= ext_hold;
                end
                default: ;
            endcase
        end
    end

endmodule
